fetch_stage: RTL and testbench

//  MIPS instruction-fetch stage: owns the program counter, drives the word-indexed address of the

---
 rtl/mips_pkg.sv | 21 ++
 rtl/fetch_stage_if.sv | 13 +
 rtl/fetch_pc_reg.sv | 35 +++
 rtl/fetch_stage.sv | 103 ++++++++++
 tb/tb_fetch_stage.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-stage types: FSM states, IF/ID register layout, reset PC and the syscall encoding.
package mips_pkg;

    localparam int          INSTR_W      = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] SYSCALL_WORD = 32'h0000_000C;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
        logic [31:0]        pc_plus4;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch -> decode handshake bundle: IF/ID contents with valid/ready.
interface fetch_stage_if #(
    parameter int DATA_SIZE = 32
);
    logic                 id_valid;
    logic                 id_ready;
    logic [DATA_SIZE-1:0] id_instr;
    logic [31:0]          id_pc;
    logic [31:0]          id_pc_plus4;

    modport master (output id_valid, id_instr, id_pc, id_pc_plus4, input id_ready);
    modport slave  (input id_valid, id_instr, id_pc, id_pc_plus4, output id_ready);
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-pc mux: redirect (word aligned) > advance (+4, wraps) > hold.
module fetch_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    input  logic        advance_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = target_i & ~32'h0000_0003;
        end else if (advance_i) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch: PC, combinational ROM lookup, IF/ID register with valid/ready to decode.
// Optional FETCH_HALT_EN: a captured syscall word parks fetch in HALT until a redirect.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int          DATA_SIZE  = INSTR_W,
    parameter int          SELEC_SIZE = 32,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [SELEC_SIZE-1:0] rom_address,
    input  logic [DATA_SIZE-1:0]  rom_out,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    fetch_stage_if.master         id,
    output logic                  halted
);

    fetch_state_t state_q, state_d;
    if_id_t       ifid_q, ifid_d;
    logic [31:0]  pc;
    logic         pc_redirect;
    logic         pc_advance;
    logic         hold;

    fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .redirect_i (pc_redirect),
        .target_i   (redirect_pc),
        .advance_i  (pc_advance),
        .pc_o       (pc)
    );

    assign rom_address = SELEC_SIZE'({2'b00, pc[31:2]});
    assign hold        = ifid_q.valid & ~id.id_ready;

    always_comb begin
        state_d     = state_q;
        ifid_d      = ifid_q;
        pc_redirect = 1'b0;
        pc_advance  = 1'b0;
        unique case (state_q)
            BOOT: begin
                pc_redirect = redirect_valid;
                state_d     = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    // Redirect kills whatever sits in IF/ID, even if decode is taking it now.
                    pc_redirect  = 1'b1;
                    ifid_d.valid = 1'b0;
                end else if (!hold) begin
                    pc_advance      = 1'b1;
                    ifid_d.valid    = 1'b1;
                    ifid_d.instr    = INSTR_W'(rom_out);
                    ifid_d.pc       = pc;
                    ifid_d.pc_plus4 = pc + 32'd4;
`ifdef FETCH_HALT_EN
                    if (rom_out == DATA_SIZE'(SYSCALL_WORD)) begin
                        state_d = HALT;
                    end
`endif
                end
            end
`ifdef FETCH_HALT_EN
            HALT: begin
                if (redirect_valid) begin
                    pc_redirect  = 1'b1;
                    ifid_d.valid = 1'b0;
                    state_d      = RUN;
                end else if (ifid_q.valid && id.id_ready) begin
                    ifid_d.valid = 1'b0;
                end
            end
`endif
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            ifid_q  <= '0;
        end else begin
            state_q <= state_d;
            ifid_q  <= ifid_d;
        end
    end

    assign id.id_valid    = ifid_q.valid;
    assign id.id_instr    = DATA_SIZE'(ifid_q.instr);
    assign id.id_pc       = ifid_q.pc;
    assign id.id_pc_plus4 = ifid_q.pc_plus4;

`ifdef FETCH_HALT_EN
    assign halted = (state_q == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand sequences, random vs reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rom_address;
    logic [31:0] rom_out;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;

    logic [31:0] rom [256];

    int checks = 0;
    int errors = 0;

    fetch_stage_if #(.DATA_SIZE(32)) id_bus ();

    fetch_stage #(
        .DATA_SIZE  (32),
        .SELEC_SIZE (32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_address    (rom_address),
        .rom_out        (rom_out),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id             (id_bus),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    assign rom_out = rom[rom_address[7:0]];

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vecs [17];

    // Reference model state (spec-level: boot flag, pc, IF/ID contents)
    logic        m_boot;
    logic [31:0] m_pc;
    logic        m_v;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " id_valid"},    32'(id_bus.id_valid), 32'd0);
        chk({tag, " id_instr"},    id_bus.id_instr,      32'd0);
        chk({tag, " id_pc"},       id_bus.id_pc,         32'd0);
        chk({tag, " id_pc_plus4"}, id_bus.id_pc_plus4,   32'd0);
        chk({tag, " rom_address"}, rom_address,          32'd0);
        chk({tag, " halted"},      32'(halted),          32'd0);
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] byte_addr);
        logic [7:0] idx;
        idx = byte_addr[9:2];
        return rom[idx];
    endfunction

    task automatic model_step(input logic redir, input logic [31:0] rpc, input logic rdy);
        logic [31:0] tgt;
        tgt = {rpc[31:2], 2'b00};
        if (m_boot) begin
            if (redir) m_pc = tgt;
            m_boot = 1'b0;
        end else if (redir) begin
            m_pc = tgt;
            m_v  = 1'b0;
        end else if (m_v && !rdy) begin
            m_v = m_v;
        end else begin
            m_instr = word_at(m_pc);
            m_ipc   = m_pc;
            m_v     = 1'b1;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'hC0DE_0000 + i;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_bus.id_ready = 1'b0;

        vecs[0]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h0};
        vecs[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h1};
        vecs[2]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         32'h2};
        vecs[3]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         32'h3};
        vecs[4]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         32'h3};
        vecs[5]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         32'h3};
        vecs[6]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         32'h3};
        vecs[7]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hC,         32'h4};
        vecs[8]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hC,         32'h4};
        vecs[9]  = '{1'b1, 32'h40,        1'b0, 1'b0, 32'h0,         32'h10};
        vecs[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h40,        32'h11};
        vecs[11] = '{1'b1, 32'h43,        1'b1, 1'b0, 32'h0,         32'h10};
        vecs[12] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h40,        32'h11};
        vecs[13] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h44,        32'h12};
        vecs[14] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,         32'h3FFF_FFFF};
        vecs[15] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0};
        vecs[16] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h1};

        // Reset state
        step();
        step();
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        // Directed table: boot latency, hold, redirect, alignment, wrap
        for (int i = 0; i < 17; i++) begin
            redirect_valid  = vecs[i].redir;
            redirect_pc     = vecs[i].rpc;
            id_bus.id_ready = vecs[i].rdy;
            step();
            chk($sformatf("vec%0d id_valid", i), 32'(id_bus.id_valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d rom_address", i), rom_address, vecs[i].eaddr);
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d id_pc", i), id_bus.id_pc, vecs[i].epc);
                chk($sformatf("vec%0d id_pc_plus4", i), id_bus.id_pc_plus4, vecs[i].epc + 32'd4);
                chk($sformatf("vec%0d id_instr", i), id_bus.id_instr, word_at(vecs[i].epc));
            end
        end
        redirect_valid = 1'b0;

        // Async reset between edges, mid-stream with a valid word held
        id_bus.id_ready = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("async_rst");
        step();
        step();
        chk_zero_outputs("async_rst_held");

`ifndef FETCH_HALT_EN
        rom[200] = 32'h0000_000C;
`endif
        // Random phase against reference model, starting from reset release
        rst_n   = 1'b1;
        m_boot  = 1'b1;
        m_pc    = 32'h0;
        m_v     = 1'b0;
        m_instr = 32'h0;
        m_ipc   = 32'h0;
        for (int c = 0; c < 600; c++) begin
            logic        r;
            logic [31:0] t;
            logic        rd;
            r  = ($urandom_range(0, 9) == 0);
            t  = $urandom;
            if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            if ($urandom_range(0, 2) == 0) t = $urandom & 32'h3FF;
            rd = ($urandom_range(0, 3) != 0);
            redirect_valid  = r;
            redirect_pc     = t;
            id_bus.id_ready = rd;
            model_step(r, t, rd);
            step();
            chk($sformatf("rnd%0d id_valid", c), 32'(id_bus.id_valid), 32'(m_v));
            chk($sformatf("rnd%0d rom_address", c), rom_address, {2'b00, m_pc[31:2]});
            chk($sformatf("rnd%0d halted", c), 32'(halted), 32'd0);
            if (m_v) begin
                chk($sformatf("rnd%0d id_pc", c), id_bus.id_pc, m_ipc);
                chk($sformatf("rnd%0d id_pc_plus4", c), id_bus.id_pc_plus4, m_ipc + 32'd4);
                chk($sformatf("rnd%0d id_instr", c), id_bus.id_instr, m_instr);
            end
        end
        redirect_valid = 1'b0;

`ifdef FETCH_HALT_EN
        // Syscall at pc 8 parks fetch; redirect to 0 resumes
        rom[2] = 32'h0000_000C;
        rst_n  = 1'b0;
        step();
        rst_n  = 1'b1;
        id_bus.id_ready = 1'b1;
        step();
        step();
        step();
        step();
        chk("halt syscall id_pc", id_bus.id_pc, 32'h8);
        chk("halt syscall id_instr", id_bus.id_instr, 32'h0000_000C);
        chk("halt halted", 32'(halted), 32'd1);
        step();
        chk("halt drained id_valid", 32'(id_bus.id_valid), 32'd0);
        chk("halt rom_address frozen", rom_address, 32'h3);
        step();
        chk("halt still halted", 32'(halted), 32'd1);
        chk("halt rom_address still", rom_address, 32'h3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        chk("resume halted", 32'(halted), 32'd0);
        chk("resume rom_address", rom_address, 32'h0);
        step();
        chk("resume id_valid", 32'(id_bus.id_valid), 32'd1);
        chk("resume id_pc", id_bus.id_pc, 32'h0);
        rom[2] = 32'hC0DE_0002;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
